// File: rtl/product_accumulator_pkg.sv
// Shared types and default constants for the product accumulator slice.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

    localparam int PROD_W_DEF = 8;
    localparam int LEN_DEF    = 4;
    localparam int ACC_W_DEF  = 10;

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and group result stream of the product accumulator.
interface product_accumulator_if
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = $clog2(LEN_DEF + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones on carry out.
module sat_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    logic [W:0] w_full;

    // Widened sum; the carry bit is the overflow indication
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b};
        o_ovf  = w_full[W];
        o_sum  = w_full[W] ? '1 : w_full[W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums incoming products into groups of up to LEN beats (or shorter on in_last)
// and presents each saturated group sum with its beat count and overflow flag.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(LEN + 1);

    acc_state_t        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_sum;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_ovf;

    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_sum;
    logic              w_add_ovf;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_close;
    logic              w_ovf_next;

    sat_adder #(.W(ACC_W)) u_add (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Beat acceptance and group-close decode; count is 0 in IDLE, which covers LEN==1
    always_comb begin
        w_prod_ext = ACC_W'(bus.in_prod);
        w_accept   = bus.in_valid & r_in_ready;
        w_cnt_next = r_count + 1'b1;
        w_close    = bus.in_last | (w_cnt_next == CNT_W'(LEN));
        w_ovf_next = r_ovf | w_add_ovf;
    end

    // Group FSM with accumulator, beat counter and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= w_cnt_next;
                        r_ovf   <= w_ovf_next;
                        if (w_close) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_next;
                            r_out_ovf   <= w_ovf_next;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_sum   <= '0;
                        r_out_count <= '0;
                        r_out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench for product_accumulator (LEN=4 and LEN=8 builds).
module tb_product_accumulator;

    localparam int ACC_W = 10;
    localparam int SMAX  = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(ACC_W), .CNT_W(3)) if4 ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(ACC_W), .CNT_W(4)) if8 ();

    product_accumulator #(.PROD_W(8), .LEN(4), .ACC_W(ACC_W)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    product_accumulator #(.PROD_W(8), .LEN(8), .ACC_W(ACC_W)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    // Reference: a saturating running sum of non-negative terms equals min(total, max)
    function automatic int unsigned ref_sum(input int unsigned total);
        return (total > SMAX) ? SMAX : total;
    endfunction

    // Offer one beat to the LEN=4 unit (called at a negedge, returns at the negedge after acceptance)
    task automatic put4(input logic [7:0] p, input logic last, output bit to);
        int unsigned n = 0;
        if4.in_valid = 1'b1;
        if4.in_prod  = p;
        if4.in_last  = last;
        while (!if4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = !if4.in_ready;
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0;
        if4.in_last  = 1'b0;
    endtask

    // Wait for a result on the LEN=4 unit, capture it, then retire it after dly stall cycles
    task automatic get4(input int unsigned dly, output logic [9:0] s, output logic [2:0] c,
                        output logic o, output bit to);
        int unsigned n = 0;
        while (!if4.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = !if4.out_valid;
        s  = if4.out_sum;
        c  = if4.out_count;
        o  = if4.out_ovf;
        repeat (dly) @(negedge clk);
        if4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        if4.in_valid = 0; if4.in_prod = 0; if4.in_last = 0; if4.out_ready = 0;
        if8.in_valid = 0; if8.in_prod = 0; if8.in_last = 0; if8.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count, if4.out_ovf} !== {1'b0, 1'b1, 10'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset4 got v=%0b r=%0b s=%0d c=%0d o=%0b want v=0 r=1 s=0 c=0 o=0",
                     if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count, if4.out_ovf);
        end
        checks++;
        if ({if8.out_valid, if8.in_ready, if8.out_sum, if8.out_count, if8.out_ovf} !== {1'b0, 1'b1, 10'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset8 got v=%0b r=%0b s=%0d c=%0d o=%0b want v=0 r=1 s=0 c=0 o=0",
                     if8.out_valid, if8.in_ready, if8.out_sum, if8.out_count, if8.out_ovf);
        end
    endtask

    task automatic test_full_group;
        bit to;
        logic [9:0] s; logic [2:0] c; logic o;
        for (int i = 0; i < 4; i++) begin
            put4(8'd225, 1'b0, to);
            checks++;
            if (to) begin errors++; $display("FAIL full_accept_timeout beat %0d", i); end
            if (i < 3) begin
                checks++;
                if (if4.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_early_valid beat %0d got %0b want 0", i, if4.out_valid);
                end
            end
        end
        checks++;
        if ({if4.out_valid, if4.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL full_latency got v=%0b r=%0b want v=1 r=0", if4.out_valid, if4.in_ready);
        end
        get4(0, s, c, o, to);
        checks++;
        if (to || s !== 10'd900 || c !== 3'd4 || o !== 1'b0) begin
            errors++;
            $display("FAIL full_result got s=%0d c=%0d o=%0b to=%0b want s=900 c=4 o=0", s, c, o, to);
        end
    endtask

    task automatic test_in_last;
        bit to;
        put4(8'd3, 1'b0, to);
        put4(8'd5, 1'b1, to);
        checks++;
        if ({if4.out_valid, if4.out_sum, if4.out_count, if4.out_ovf} !== {1'b1, 10'd8, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL last_result got v=%0b s=%0d c=%0d o=%0b want v=1 s=8 c=2 o=0",
                     if4.out_valid, if4.out_sum, if4.out_count, if4.out_ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL last_hold cyc %0d got r=%0b v=%0b want r=0 v=1", i, if4.in_ready, if4.out_valid);
            end
        end
        if4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
        checks++;
        if ({if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count} !== {1'b0, 1'b1, 10'd0, 3'd0}) begin
            errors++;
            $display("FAIL last_retire got v=%0b r=%0b s=%0d c=%0d want v=0 r=1 s=0 c=0",
                     if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 8; i++) begin
            if8.in_valid = 1'b1; if8.in_prod = 8'd225; if8.in_last = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        checks++;
        if ({if8.out_valid, if8.out_sum, if8.out_count, if8.out_ovf} !== {1'b1, 10'd1023, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL sat_result got v=%0b s=%0d c=%0d o=%0b want v=1 s=1023 c=8 o=1",
                     if8.out_valid, if8.out_sum, if8.out_count, if8.out_ovf);
        end
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.out_ready = 1'b0;
        if8.in_valid = 1'b1; if8.in_prod = 8'd1; if8.in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.in_prod = 8'd2; if8.in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0; if8.in_last = 1'b0;
        checks++;
        if ({if8.out_valid, if8.out_sum, if8.out_count, if8.out_ovf} !== {1'b1, 10'd3, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL sat_next_group got v=%0b s=%0d c=%0d o=%0b want v=1 s=3 c=2 o=0",
                     if8.out_valid, if8.out_sum, if8.out_count, if8.out_ovf);
        end
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit to;
        int unsigned total = 0;
        logic [7:0] p;
        logic [7:0] x;
        logic [9:0] s; logic [2:0] c; logic o;
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom_range(255));
            total += p;
            put4(p, 1'b0, to);
        end
        x = 8'($urandom_range(255));
        if4.in_valid = 1'b1; if4.in_prod = x; if4.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (if4.out_valid !== 1'b1 || if4.out_sum !== 10'(ref_sum(total)) || if4.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall cyc %0d got v=%0b s=%0d r=%0b want v=1 s=%0d r=0",
                         i, if4.out_valid, if4.out_sum, if4.in_ready, ref_sum(total));
            end
        end
        if4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
        checks++;
        if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retire got v=%0b r=%0b want v=0 r=1", if4.out_valid, if4.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0; if4.in_last = 1'b0;
        checks++;
        if ({if4.out_valid, if4.out_sum, if4.out_count, if4.out_ovf} !== {1'b1, 10'(x), 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_pending got v=%0b s=%0d c=%0d o=%0b want v=1 s=%0d c=1 o=0",
                     if4.out_valid, if4.out_sum, if4.out_count, if4.out_ovf, x);
        end
        get4(0, s, c, o, to);
    endtask

    task automatic test_reset_mid;
        bit to;
        logic [9:0] s; logic [2:0] c; logic o;
        put4(8'd100, 1'b0, to);
        put4(8'd50, 1'b0, to);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count, if4.out_ovf} !== {1'b0, 1'b1, 10'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_async got v=%0b r=%0b s=%0d c=%0d o=%0b want v=0 r=1 s=0 c=0 o=0",
                     if4.out_valid, if4.in_ready, if4.out_sum, if4.out_count, if4.out_ovf);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if4.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_valid cyc %0d got %0b want 0", i, if4.out_valid);
            end
        end
        for (int i = 0; i < 4; i++) put4(8'd4, 1'b0, to);
        get4(1, s, c, o, to);
        checks++;
        if (to || s !== 10'd16 || c !== 3'd4 || o !== 1'b0) begin
            errors++;
            $display("FAIL rst_regroup got s=%0d c=%0d o=%0b to=%0b want s=16 c=4 o=0", s, c, o, to);
        end
    endtask

    task automatic test_random;
        bit to;
        logic [9:0] s; logic [2:0] c; logic o;
        int unsigned len, total, gap;
        logic [7:0] p;
        logic last;
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 4);
            total = 0;
            for (int i = 0; i < int'(len); i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    if4.in_prod = 8'($urandom);
                    if4.in_last = 1'($urandom);
                    @(negedge clk);
                end
                p = 8'($urandom_range(255));
                total += p;
                last = (i == int'(len) - 1) ? ((len < 4) ? 1'b1 : 1'($urandom)) : 1'b0;
                put4(p, last, to);
            end
            get4($urandom_range(0, 3), s, c, o, to);
            checks++;
            if (to || s !== 10'(ref_sum(total)) || c !== 3'(len) || o !== (total > SMAX)) begin
                errors++;
                $display("FAIL random grp %0d got s=%0d c=%0d o=%0b to=%0b want s=%0d c=%0d o=%0b",
                         g, s, c, o, to, ref_sum(total), len, total > SMAX);
            end
        end
    endtask

    task automatic test_mult_sweep;
        bit to;
        logic [9:0] s; logic [2:0] c; logic o;
        int unsigned total = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                total += a * b;
                put4(8'(a * b), 1'b0, to);
                if ((b % 4) == 3) begin
                    get4(0, s, c, o, to);
                    checks++;
                    if (to || s !== 10'(total) || c !== 3'd4 || o !== 1'b0) begin
                        errors++;
                        $display("FAIL mult a=%0d b=%0d got s=%0d c=%0d o=%0b want s=%0d c=4 o=0",
                                 a, b, s, c, o, total);
                    end
                    total = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_group;
        test_in_last;
        test_saturation;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_mult_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
